// File: rtl/ysyx_25040111_ch_pkg.sv
// ysyx_25040111_ch_pkg: shared FSM state type and AXI4 encodings for the line-fill responder
package ysyx_25040111_ch_pkg;
  typedef enum logic [1:0] {CH_IDLE, CH_AR, CH_R, CH_DRAIN} ch_state_t;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
endpackage

// File: rtl/ysyx_25040111_watchdog.sv
// ysyx_25040111_watchdog: pulses expired after TIMEOUT enabled cycles with no clear; TIMEOUT=0 disables it
module ysyx_25040111_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [W-1:0] cnt;
  assign expired = TIMEOUT != 0 && enable && !clear && cnt == W'(TIMEOUT - 1);
  always_ff @(posedge clock or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= clear || !enable || expired ? '0 : cnt + 1'b1;
endmodule

// File: rtl/ysyx_25040111_chresp.sv
// ysyx_25040111_chresp: ICache line-fill responder, fetches a line over AXI4 (burst or per-word) and returns words on chready
module ysyx_25040111_chresp
  import ysyx_25040111_ch_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        chvalid,
  input  logic        chburst,
  input  logic [31:0] chaddr,
  input  logic [7:0]  chlen,
  output logic        chready,
  output logic [31:0] chdata,
  output logic        err,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast
);
  ch_state_t state, nxt;
  logic [7:0] len_q, beat;
  logic burst_q, ar_hs, r_hs, r_ok, take, last, expired;
  assign ar_hs = arvalid && arready;
  assign r_hs  = state == CH_R && rvalid;
  assign last  = beat == len_q;
  assign r_ok  = rresp == AXI_RESP_OKAY && (burst_q ? rlast == last : rlast);
  assign take  = r_hs && r_ok;
  // AR fields track chaddr/chburst live; the initiator holds them steady while arvalid is up
  assign araddr  = arvalid ? chaddr : '0;
  assign arlen   = arvalid && chburst ? len_q : '0;
  assign arsize  = arvalid ? AXI_SIZE_4B : '0;
  assign arburst = arvalid ? AXI_BURST_INCR : '0;
  ysyx_25040111_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clock  (clock),
    .reset  (reset),
    .clear  (ar_hs || r_hs),
    .enable (state == CH_AR || state == CH_R),
    .expired(expired)
  );
  // A visible chready means the initiator is about to drop chvalid, so IDLE ignores it that cycle
  always_comb begin
    nxt = state;
    case (state)
      CH_IDLE:  nxt = chvalid && !chready ? CH_AR : CH_IDLE;
      CH_AR:    nxt = ar_hs ? CH_R : expired ? CH_IDLE : CH_AR;
      CH_R:     nxt = rvalid ? (r_ok ? (last ? CH_IDLE : burst_q ? CH_R : CH_AR)
                                     : rlast ? CH_IDLE : CH_DRAIN)
                             : expired ? CH_DRAIN : CH_R;
      CH_DRAIN: nxt = rvalid && rlast ? CH_IDLE : CH_DRAIN;
      default:  nxt = CH_IDLE;
    endcase
  end
  // Re-entering AR from R waits one cycle so the initiator's advanced chaddr is in place before arvalid
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state   <= CH_IDLE;
      arvalid <= 1'b0;
      rready  <= 1'b0;
      chready <= 1'b0;
      chdata  <= '0;
      err     <= 1'b0;
      len_q   <= '0;
      beat    <= '0;
      burst_q <= 1'b0;
    end else begin
      state   <= nxt;
      arvalid <= nxt == CH_AR && state != CH_R;
      rready  <= nxt == CH_R || nxt == CH_DRAIN;
      chready <= take;
      err     <= (r_hs && !r_ok) || expired;
      if (take) chdata <= rdata;
      if (take) beat <= beat + 8'd1;
      if (ar_hs) burst_q <= chburst;
      if (state == CH_IDLE && nxt == CH_AR) begin
        len_q <= chlen;
        beat  <= '0;
      end
    end
endmodule

// File: tb/tb_ysyx_25040111_chresp.sv
// tb_ysyx_25040111_chresp: table-driven line fills with a chdata scoreboard, plus watchdog and reset sequences
module tb_ysyx_25040111_chresp;
  logic        clock = 1'b0;
  logic        reset;
  logic        chvalid, chburst;
  logic [31:0] chaddr;
  logic [7:0]  chlen;
  logic        chready, err;
  logic [31:0] chdata;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready, rlast;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  ysyx_25040111_chresp #(.TIMEOUT(8)) dut (
    .clock(clock), .reset(reset), .chvalid(chvalid), .chburst(chburst), .chaddr(chaddr),
    .chlen(chlen), .chready(chready), .chdata(chdata), .err(err), .arvalid(arvalid),
    .arready(arready), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          burst;
    logic [7:0]  len;
    logic [31:0] addr;
    int          bad;
    int          early;
    logic [31:0] dbase;
    int          n_rdy;
    int          n_err;
    int          n_ar;
  } vec_t;

  vec_t        vt[8];
  logic [31:0] exp_q[$];
  logic [31:0] obs[$];
  int          rd = 0, rdy_seen = 0, err_seen = 0;
  int          total = 0, passed = 0;

  always @(negedge clock) begin
    if (chready) begin
      obs.push_back(chdata);
      rdy_seen++;
    end
    if (err) err_seen++;
  end

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  task automatic sb_check();
    while (rd < obs.size()) begin
      if (exp_q.size() == 0) begin
        check("sb_extra_chready", 64'(obs.size() - rd), 64'd0);
        rd = obs.size();
      end else begin
        check("sb_chdata", 64'(obs[rd]), 64'(exp_q.pop_front()));
        rd++;
      end
    end
    check("sb_missing_chready", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic wait_ar(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (arvalid) begin
        ok = 1'b1;
        return;
      end
      @(negedge clock);
    end
  endtask

  task automatic xfer(input vec_t v);
    bit ok, lst, good, done;
    int b, nar, r0, e0, stale;
    r0 = rdy_seen; e0 = err_seen; b = 0; nar = 0; done = 1'b0;
    chburst = v.burst; chaddr = v.addr; chlen = v.len; chvalid = 1'b1;
    while (!done) begin
      wait_ar(ok);
      if (!ok) begin
        check("ar_wait_expired", 64'(ok), 64'd1);
        break;
      end
      nar++;
      check("araddr", 64'(araddr), 64'(v.addr + (v.burst ? 32'd0 : 32'(4 * b))));
      check("arlen", 64'(arlen), 64'(v.burst ? v.len : 8'd0));
      check("arsize_arburst", 64'({arsize, arburst}), 64'(5'b010_01));
      arready = 1'b1;
      @(negedge clock);
      arready = 1'b0;
      do begin
        lst  = v.burst ? (b == int'(v.len) || b == v.early) : 1'b1;
        good = b != v.bad && b != v.early;
        rvalid = 1'b1; rdata = v.dbase + 32'(b); rresp = b == v.bad ? 2'b10 : 2'b00; rlast = lst;
        if (good) exp_q.push_back(rdata);
        @(negedge clock);
        b++;
        if (!good) begin
          chvalid = 1'b0;
          if (!lst)
            for (int k = b; k <= int'(v.len); k++) begin
              rresp = 2'b00; rdata = v.dbase + 32'(k); rlast = k == int'(v.len);
              @(negedge clock);
            end
          done = 1'b1;
        end else if (b > int'(v.len)) done = 1'b1;
        else if (!v.burst) begin
          rvalid = 1'b0;
          @(posedge clock);
          #1 chaddr += 32'd4;
          @(negedge clock);
        end
      end while (v.burst && !done);
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    if (chvalid) begin
      @(posedge clock);
      #1 chvalid = 1'b0;
    end
    stale = 0;
    repeat (4) begin
      @(negedge clock);
      if (arvalid) stale++;
    end
    check("no_retrigger", 64'(stale), 64'd0);
    check("idle_rready", 64'(rready), 64'd0);
    check("n_ar", 64'(nar), 64'(v.n_ar));
    check("n_chready", 64'(rdy_seen - r0), 64'(v.n_rdy));
    check("n_err", 64'(err_seen - e0), 64'(v.n_err));
    sb_check();
  endtask

  initial begin
    #400000;
    $display("FAIL global_time_limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    int hi, at, arv, rr, e0;
    vt[0] = '{1'b1, 8'd3, 32'h3000_0010, -1, -1, 32'h0000_00A0, 4, 0, 1};
    vt[1] = '{1'b0, 8'd3, 32'h3000_0010, -1, -1, 32'h0000_00B0, 4, 0, 4};
    vt[2] = '{1'b1, 8'd3, 32'h3000_0020,  1, -1, 32'h0000_00C0, 1, 1, 1};
    vt[3] = '{1'b1, 8'd3, 32'h3000_0030, -1,  2, 32'h0000_00C8, 2, 1, 1};
    vt[4] = '{1'b1, 8'd0, 32'h8000_0000, -1, -1, 32'h0000_00D0, 1, 0, 1};
    vt[5] = '{1'b0, 8'd1, 32'h8000_1000,  1, -1, 32'h0000_00D8, 1, 1, 2};
    vt[6] = '{1'b1, 8'd7, 32'h3000_0100, -1, -1, 32'h0000_00E0, 8, 0, 1};
    vt[7] = '{1'b0, 8'd0, 32'h3000_0200, -1, -1, 32'h0000_00F8, 1, 0, 1};
    reset = 1'b1; chvalid = 1'b0; chburst = 1'b0; chaddr = '0; chlen = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0;
    repeat (2) @(negedge clock);
    check("reset_ctrl", 64'({chready, err, arvalid, rready, arlen, arsize, arburst}), 64'd0);
    check("reset_data", 64'({chdata, araddr}), 64'd0);
    reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 8; i++) xfer(vt[i]);

    // AR never accepted: eight cycles of arvalid, then err with arvalid already low
    e0 = err_seen; hi = 0; at = 0; arv = 1;
    chburst = 1'b1; chaddr = 32'h3000_0300; chlen = 8'd3; chvalid = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      if (err) begin
        at = n; arv = arvalid;
        break;
      end
      if (arvalid) hi++;
    end
    chvalid = 1'b0;
    check("wd_ar_err_cycle", 64'(at), 64'd9);
    check("wd_ar_arvalid_cycles", 64'(hi), 64'd8);
    check("wd_ar_arvalid_dropped", 64'(arv), 64'd0);
    repeat (3) @(negedge clock);
    check("wd_ar_stays_idle", 64'(arvalid), 64'd0);
    check("wd_ar_one_err", 64'(err_seen - e0), 64'd1);

    // R beats stalled: err after eight idle cycles, then DRAIN keeps rready until rlast
    e0 = err_seen; at = 0; rr = 0;
    chburst = 1'b1; chaddr = 32'h3000_0400; chlen = 8'd1; chvalid = 1'b1;
    wait_ar(ok);
    check("wd_r_ar_seen", 64'(ok), 64'd1);
    arready = 1'b1;
    @(negedge clock);
    arready = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (err) begin
        at = n; rr = rready;
        break;
      end
      @(negedge clock);
    end
    chvalid = 1'b0;
    check("wd_r_err_cycle", 64'(at), 64'd9);
    check("wd_r_drain_rready", 64'(rr), 64'd1);
    rvalid = 1'b1; rdata = 32'h55; rlast = 1'b1;
    @(negedge clock);
    rvalid = 1'b0; rlast = 1'b0;
    @(negedge clock);
    check("wd_r_idle_after_drain", 64'(rready), 64'd0);
    check("wd_r_one_err", 64'(err_seen - e0), 64'd1);
    sb_check();

    // Asynchronous reset in the middle of a burst after two returned words
    chburst = 1'b1; chaddr = 32'h3000_0040; chlen = 8'd3; chvalid = 1'b1;
    wait_ar(ok);
    check("rst_ar_seen", 64'(ok), 64'd1);
    arready = 1'b1;
    @(negedge clock);
    arready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rvalid = 1'b1; rdata = 32'hF0 + 32'(k); rresp = 2'b00; rlast = 1'b0;
      exp_q.push_back(rdata);
      @(negedge clock);
    end
    rvalid = 1'b0;
    #2 reset = 1'b1; chvalid = 1'b0;
    #1;
    check("midrst_ctrl", 64'({chready, err, arvalid, rready, arlen, arsize, arburst}), 64'd0);
    check("midrst_data", 64'({chdata, araddr}), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    sb_check();
    xfer(vt[0]);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
